// File: rtl/execute_stage_if.sv
// Handshake and result bus between the decode stage, the execute stage, and the EX/MEM boundary.
interface execute_stage_if #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [WIDTH-1:0]    imm;
  logic [WIDTH-1:0]    next_pc;
  logic [2:0]          alu_op;
  logic                src2_imm;
  logic [2:0]          br_cond;
  logic [1:0]          jmp_mode;
  logic                link;
  logic [1:0]          dst_sel;
  logic [REG_BITS-1:0] fld0;
  logic [REG_BITS-1:0] fld1;
  logic [REG_BITS-1:0] fld2;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_result;
  logic [REG_BITS-1:0] out_wr_reg;
  logic [WIDTH-1:0]    out_target_pc;
  logic                out_redirect;
  logic                out_reg7_en;
  logic                err;

  modport master (
    output in_valid, a, b, imm, next_pc, alu_op, src2_imm, br_cond, jmp_mode, link,
           dst_sel, fld0, fld1, fld2, out_ready,
    input  in_ready, out_valid, out_result, out_wr_reg, out_target_pc, out_redirect,
           out_reg7_en, err
  );

  modport slave (
    input  in_valid, a, b, imm, next_pc, alu_op, src2_imm, br_cond, jmp_mode, link,
           dst_sel, fld0, fld1, fld2, out_ready,
    output in_ready, out_valid, out_result, out_wr_reg, out_target_pc, out_redirect,
           out_reg7_en, err
  );
endinterface

// File: rtl/execute_stage_pipe.sv
// Registered execute stage: ALU, branch/jump target, link handling, output register with backpressure.
// Define EX_MUL_EN to build the iterative shift-add multiplier; otherwise alu_op 111 flags err.
//
// state    | meaning
// IDLE     | accepting operations
// MUL      | one multiplier bit per cycle, WIDTH cycles
// WAIT_OUT | product ready, waiting for output register to free up
module execute_stage_pipe #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3,
  parameter int LINK_REG = 2**REG_BITS-1
) (
  input logic           clk,
  input logic           rst,
  execute_stage_if.slave ex
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0]    src2, alu_res, target;
  logic [REG_BITS-1:0] dst;
  logic                taken, lnk, out_free, accept, is_mul, accept_alu;

  logic                v_r, redirect_r, reg7_r, err_r;
  logic [WIDTH-1:0]    result_r, target_r;
  logic [REG_BITS-1:0] wr_reg_r;

  assign src2     = ex.src2_imm ? ex.imm : ex.b;
  assign lnk      = (ex.jmp_mode == 2'b11) | ex.link;
  assign out_free = !v_r | ex.out_ready;

  always_comb begin
    alu_res = '0;
    case (ex.alu_op)
      3'b000:  alu_res = ex.a + src2;
      3'b001:  alu_res = src2 - ex.a;
      3'b010:  alu_res = ex.a & src2;
      3'b011:  alu_res = ex.a ^ src2;
      3'b100:  alu_res = ex.a << src2[SW-1:0];
      3'b101:  alu_res = ex.a >> src2[SW-1:0];
      3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(ex.a) < $signed(src2))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (ex.br_cond)
      3'b001:  taken = (ex.a == '0);
      3'b010:  taken = (ex.a != '0);
      3'b011:  taken = ex.a[WIDTH-1];
      3'b100:  taken = !ex.a[WIDTH-1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target = ex.next_pc;
    if (ex.jmp_mode == 2'b01)      target = ex.next_pc + ex.imm;
    else if (ex.jmp_mode[1])       target = ex.a + ex.imm;
    else if (taken)                target = ex.next_pc + ex.imm;
  end

  always_comb begin
    dst = ex.fld0;
    case (ex.dst_sel)
      2'b00:   dst = ex.fld0;
      2'b01:   dst = ex.fld1;
      2'b10:   dst = ex.fld2;
      default: dst = REG_BITS'(LINK_REG);
    endcase
  end

  // A linking op always takes the single-cycle path so the link value wins over MUL.
  assign is_mul = (ex.alu_op == 3'b111) & !lnk;

`ifdef EX_MUL_EN
  localparam int CW = (SW > 0) ? SW : 1;

  typedef enum logic [1:0] {IDLE, MUL, WAIT_OUT} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]    mcand, mplier, acc, acc_next, mul_val, mul_pc;
  logic [REG_BITS-1:0] mul_dst;
  logic [CW-1:0]       cnt;
  logic                mul_last, mul_load;

  assign ex.in_ready = (state == IDLE) & out_free;
  assign accept      = ex.in_valid & ex.in_ready;
  assign accept_alu  = accept & !is_mul;
  assign acc_next    = acc + (mplier[0] ? mcand : '0);
  assign mul_last    = (cnt == CW'(WIDTH-1));
  assign mul_val     = (state == MUL) ? acc_next : acc;
  assign mul_load    = ((state == MUL) & mul_last & out_free) | ((state == WAIT_OUT) & out_free);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept & is_mul) state_nxt = MUL;
      MUL:      if (mul_last) state_nxt = out_free ? IDLE : WAIT_OUT;
      WAIT_OUT: if (out_free) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      mul_dst <= '0;
      mul_pc  <= '0;
    end else if (accept & is_mul) begin
      mcand   <= ex.a;
      mplier  <= src2;
      acc     <= '0;
      cnt     <= '0;
      mul_dst <= dst;
      mul_pc  <= ex.next_pc;
    end else if (state == MUL) begin
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      acc     <= acc_next;
      cnt     <= cnt + 1'b1;
    end
  end

  assign err_r = 1'b0;
`else
  assign ex.in_ready = out_free;
  assign accept      = ex.in_valid & ex.in_ready;
  assign accept_alu  = accept;

  always_ff @(posedge clk) begin
    if (!rst)                   err_r <= 1'b0;
    else if (accept & is_mul)   err_r <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_r        <= 1'b0;
      result_r   <= '0;
      wr_reg_r   <= '0;
      target_r   <= '0;
      redirect_r <= 1'b0;
      reg7_r     <= 1'b0;
    end else if (accept_alu) begin
      v_r        <= 1'b1;
      result_r   <= lnk ? ex.next_pc : alu_res;
      wr_reg_r   <= lnk ? REG_BITS'(LINK_REG) : dst;
      target_r   <= target;
      redirect_r <= taken | (ex.jmp_mode != 2'b00);
      reg7_r     <= lnk;
`ifdef EX_MUL_EN
    end else if (mul_load) begin
      v_r        <= 1'b1;
      result_r   <= mul_val;
      wr_reg_r   <= mul_dst;
      target_r   <= mul_pc;
      redirect_r <= 1'b0;
      reg7_r     <= 1'b0;
`endif
    end else if (ex.out_ready) begin
      v_r        <= 1'b0;
    end
  end

  assign ex.out_valid     = v_r;
  assign ex.out_result    = result_r;
  assign ex.out_wr_reg    = wr_reg_r;
  assign ex.out_target_pc = target_r;
  assign ex.out_redirect  = redirect_r;
  assign ex.out_reg7_en   = reg7_r;
  assign ex.err           = err_r;
endmodule
